uart_mmio_bridge: RTL and testbench

UART_MMIO_BRIDGE -- requirements
Module: uart_mmio_bridge

---
 rtl/uart_mmio_bridge.sv | 191 +++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: memory-mapped register front end for a UART Tx/Rx pair.
// Bus handshake: a request (bus_we or bus_re) is accepted only in IDLE and
// takes effect on that clock edge. The following cycle is ACK, where
// bus_ready=1 for exactly one cycle and bus_rdata carries the read value.
// Requests seen during ACK are ignored. bus_rdata is 0 whenever bus_ready=0.
// If bus_we and bus_re are both high, only the write is performed.
module uart_mmio_bridge #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        uart_send,
  output logic [7:0]  uart_data,
  output logic [1:0]  uart_parity_type,
  output logic [1:0]  uart_baud_rate,
  input  logic        uart_tx_full,
  input  logic        uart_tx_empty,
  input  logic        uart_tx_active,
  input  logic        uart_rx_done,
  input  logic [7:0]  uart_rx_data,
  input  logic [2:0]  uart_error,
  output logic        irq,
  output logic        dbg_bus_state
);

  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CW = $clog2(RX_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(RX_DEPTH);

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_CTRL   = 4'hC;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } bus_state_e;

  bus_state_e     state_q, state_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           send_q, send_d;
  logic [7:0]     data_q, data_d;
  logic [5:0]     ctrl_q, ctrl_d;
  logic           txovf_q, txovf_d;
  logic           rxovf_q, rxovf_d;
  logic [2:0]     err_q, err_d;
  logic           irq_q, irq_d;
  logic           rx_done_q;
  logic           rx_armed_q;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     mem_q [RX_DEPTH];

  logic           access, do_wr, do_rd;
  logic           rx_edge, q_empty, q_full, push, pop;
  logic [4:0]     clr;
  logic [31:0]    status_word;
  logic           unused_wdata;

  assign unused_wdata = ^bus_wdata[31:10];

  // Access decode, RX queue control, sticky flags and read mux.
  always_comb begin
    state_d = state_q;
    rdata_d = 32'd0;
    send_d  = 1'b0;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    clr     = 5'd0;

    access  = (state_q == S_IDLE) && (bus_we || bus_re);
    do_wr   = access && bus_we;
    do_rd   = access && !bus_we && bus_re;

    // Edge detect gated by "armed" so a level already high at reset release is ignored.
    rx_edge = uart_rx_done && !rx_done_q && rx_armed_q;
    q_empty = (count_q == '0);
    q_full  = (count_q == FULL_COUNT);
    // Both push and pop judge fullness/emptiness on the pre-update count.
    push    = rx_edge && !q_full;
    pop     = do_rd && (bus_addr == ADDR_RXDATA) && !q_empty;

    status_word = {22'd0, err_q, rxovf_q, txovf_q, q_full, !q_empty,
                   uart_tx_active, uart_tx_empty, uart_tx_full};

    unique case (state_q)
      S_IDLE: if (access) state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (do_wr) begin
      unique case (bus_addr)
        ADDR_TXDATA: begin
          if (!uart_tx_full) begin
            send_d = 1'b1;
            data_d = bus_wdata[7:0];
          end
        end
        ADDR_STATUS: clr = bus_wdata[9:5];
        ADDR_CTRL:   ctrl_d = bus_wdata[5:0];
        default: ;
      endcase
    end

    if (do_rd) begin
      unique case (bus_addr)
        ADDR_RXDATA: rdata_d = q_empty ? 32'd0 : {23'd0, 1'b1, mem_q[rptr_q]};
        ADDR_STATUS: rdata_d = status_word;
        ADDR_CTRL:   rdata_d = {26'd0, ctrl_q};
        default:     rdata_d = 32'd0;
      endcase
    end

    // Clear first, then set, so a same-cycle set wins over W1C.
    txovf_d = (txovf_q & ~clr[0]) |
              (do_wr && (bus_addr == ADDR_TXDATA) && uart_tx_full);
    rxovf_d = (rxovf_q & ~clr[1]) | (rx_edge && q_full);
    err_d   = (err_q & ~clr[4:2]) | (rx_edge ? uart_error : 3'd0);

    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    irq_d = (ctrl_q[4] && !q_empty) ||
            (ctrl_q[5] && uart_tx_empty) ||
            (ctrl_q[4] && (rxovf_q || (err_q != 3'd0)));
  end

  // State, registers, queue pointers and stickies; all cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rdata_q    <= 32'd0;
      send_q     <= 1'b0;
      data_q     <= 8'd0;
      ctrl_q     <= 6'd0;
      txovf_q    <= 1'b0;
      rxovf_q    <= 1'b0;
      err_q      <= 3'd0;
      irq_q      <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_armed_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      send_q     <= send_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      txovf_q    <= txovf_d;
      rxovf_q    <= rxovf_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      rx_done_q  <= uart_rx_done;
      rx_armed_q <= rx_armed_q | ~uart_rx_done;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // RX holding storage; validity is tracked by the pointers and count alone.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= uart_rx_data;
  end

  assign bus_ready        = (state_q == S_ACK);
  assign bus_rdata        = bus_ready ? rdata_q : 32'd0;
  assign uart_send        = send_q;
  assign uart_data        = data_q;
  assign uart_parity_type = ctrl_q[1:0];
  assign uart_baud_rate   = ctrl_q[3:2];
  assign irq              = irq_q;
  assign dbg_bus_state    = state_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Bench for uart_mmio_bridge: directed scenarios followed by randomized
// register traffic, checked against a queue-based model of the bridge.
module tb_uart_mmio_bridge;
  localparam int RX_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0, bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_ready, uart_send, irq, dbg_bus_state;
  logic [7:0]  uart_data;
  logic [1:0]  uart_parity_type, uart_baud_rate;
  logic        uart_tx_full = 1'b0, uart_tx_empty = 1'b1, uart_tx_active = 1'b0;
  logic        uart_rx_done = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic [2:0]  uart_error = '0;

  uart_mmio_bridge #(.RX_DEPTH(RX_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .uart_send(uart_send), .uart_data(uart_data), .uart_parity_type(uart_parity_type),
    .uart_baud_rate(uart_baud_rate), .uart_tx_full(uart_tx_full),
    .uart_tx_empty(uart_tx_empty), .uart_tx_active(uart_tx_active),
    .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data), .uart_error(uart_error),
    .irq(irq), .dbg_bus_state(dbg_bus_state)
  );

  // Clock generation
  always #5 clock = ~clock;

  // Reference model state
  logic [7:0] exp_q[$];
  logic       m_txovf, m_rxovf;
  logic [2:0] m_err;
  logic [5:0] m_ctrl;
  logic [7:0] m_data;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_txovf = 0; m_rxovf = 0; m_err = 0; m_ctrl = 0; m_data = 0;
  endtask

  function automatic logic model_irq();
    return (m_ctrl[4] && exp_q.size() > 0) || (m_ctrl[5] && uart_tx_empty) ||
           (m_ctrl[4] && (m_rxovf || m_err != 0));
  endfunction

  // A received byte: dropped with RXOVF if the queue was full beforehand.
  task automatic model_rx(input int pre_n, input logic [7:0] b, input logic [2:0] e);
    if (pre_n == RX_DEPTH) m_rxovf = 1'b1;
    else exp_q.push_back(b);
    m_err = m_err | e;
  endtask

  // One rx_done pulse with no bus access.
  task automatic rx_event(input logic [7:0] b, input logic [2:0] e);
    int pre_n;
    @(negedge clock);
    uart_rx_done = 1'b1; uart_rx_data = b; uart_error = e;
    pre_n = exp_q.size();
    model_rx(pre_n, b, e);
    @(negedge clock);
    uart_rx_done = 1'b0; uart_error = 3'd0;
  endtask

  // One bus access, optionally with an rx_done edge in the same cycle.
  task automatic do_access(input logic we, input logic re, input logic [3:0] addr,
                           input logic [31:0] wdata, input logic with_rx,
                           input logic [7:0] rb, input logic [2:0] rerr,
                           output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_send, tx_set;
    logic [4:0]  clr;
    int          pre_n;
    @(negedge clock);
    bus_we = we; bus_re = re; bus_addr = addr; bus_wdata = wdata;
    if (with_rx) begin
      uart_rx_done = 1'b1; uart_rx_data = rb; uart_error = rerr;
    end
    pre_n = exp_q.size();
    exp_rd = 0; exp_send = 0; tx_set = 0; clr = 0;
    if (we) begin
      case (addr)
        4'h0: if (!uart_tx_full) begin exp_send = 1; m_data = wdata[7:0]; end
              else tx_set = 1;
        4'h8: clr = wdata[9:5];
        4'hC: m_ctrl = wdata[5:0];
        default: ;
      endcase
    end else if (re) begin
      case (addr)
        4'h4: if (pre_n > 0) exp_rd = 32'h100 | 32'(exp_q.pop_front());
        4'h8: exp_rd = (32'(m_err) << 7) | (32'(m_rxovf) << 6) | (32'(m_txovf) << 5) |
                       (32'(pre_n == RX_DEPTH) << 4) | (32'(pre_n > 0) << 3) |
                       (32'(uart_tx_active) << 2) | (32'(uart_tx_empty) << 1) |
                       32'(uart_tx_full);
        4'hC: exp_rd = 32'(m_ctrl);
        default: exp_rd = 0;
      endcase
    end
    m_txovf = (m_txovf & ~clr[0]) | tx_set;
    m_rxovf = m_rxovf & ~clr[1];
    m_err   = m_err & ~clr[4:2];
    if (with_rx) model_rx(pre_n, rb, rerr);
    @(negedge clock);
    chk("ack_ready", 32'(bus_ready), 1);
    chk("ack_rdata", bus_rdata, exp_rd);
    chk("ack_send", 32'(uart_send), 32'(exp_send));
    chk("uart_data", 32'(uart_data), 32'(m_data));
    rd = bus_rdata;
    bus_we = 0; bus_re = 0; uart_rx_done = 0; uart_error = 0;
    @(negedge clock);
    chk("idle_ready", 32'(bus_ready), 0);
    chk("idle_rdata", bus_rdata, 0);
    chk("idle_send", 32'(uart_send), 0);
    chk("parity", 32'(uart_parity_type), 32'(m_ctrl[1:0]));
    chk("baud", 32'(uart_baud_rate), 32'(m_ctrl[3:2]));
    chk("irq", 32'(irq), 32'(model_irq()));
  endtask

  logic [31:0] rd;

  initial begin
    // Reset with rx_done already high: it must not be captured after release.
    model_reset();
    uart_rx_done = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(bus_ready), 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_send", 32'(uart_send), 0);
    chk("rst_data", 32'(uart_data), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_cfg", {28'd0, uart_parity_type, uart_baud_rate}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    do_access(0, 1, 4'h8, 0, 0, 0, 0, rd);
    chk("no_capture_at_release", rd & 32'h18, 32'h0);
    uart_rx_done = 1'b0;

    // TXDATA write, FIFO not full
    uart_tx_full = 0; uart_tx_empty = 1; uart_tx_active = 0;
    do_access(1, 0, 4'h0, 32'h5A, 0, 0, 0, rd);
    chk("tx_data_5a", 32'(uart_data), 32'h5A);

    // TXDATA write, FIFO full: dropped, TXOVF set, cleared by W1C
    uart_tx_full = 1; uart_tx_empty = 0;
    do_access(1, 0, 4'h0, 32'h33, 0, 0, 0, rd);
    chk("tx_full_data_kept", 32'(uart_data), 32'h5A);
    do_access(0, 1, 4'h8, 0, 0, 0, 0, rd);
    chk("status_txovf", rd, 32'h21);
    do_access(1, 0, 4'h8, 32'h20, 0, 0, 0, rd);
    do_access(0, 1, 4'h8, 0, 0, 0, 0, rd);
    chk("status_txovf_clr", rd, 32'h01);
    uart_tx_full = 0;

    // Overflow the RX queue
    for (int i = 1; i <= 5; i++) rx_event(8'(i), 3'd0);
    do_access(0, 1, 4'h8, 0, 0, 0, 0, rd);
    chk("rxovf_set", rd & 32'h58, 32'h58);
    for (int i = 1; i <= 4; i++) begin
      do_access(0, 1, 4'h4, 0, 0, 0, 0, rd);
      chk("rx_order", rd, 32'h100 + 32'(i));
    end
    do_access(0, 1, 4'h4, 0, 0, 0, 0, rd);
    chk("rx_empty_read", rd, 32'h0);
    do_access(1, 0, 4'h8, 32'h40, 0, 0, 0, rd);

    // Same-cycle push and pop at count=2, then at count=0
    rx_event(8'hA1, 0);
    rx_event(8'hA2, 0);
    do_access(0, 1, 4'h4, 0, 1, 8'hA3, 0, rd);
    chk("pushpop_first", rd, 32'h1A1);
    do_access(0, 1, 4'h8, 0, 0, 0, 0, rd);
    chk("pushpop_count2", rd & 32'h18, 32'h08);
    do_access(0, 1, 4'h4, 0, 0, 0, 0, rd);
    chk("pushpop_second", rd, 32'h1A2);
    do_access(0, 1, 4'h4, 0, 0, 0, 0, rd);
    chk("pushpop_third", rd, 32'h1A3);
    do_access(0, 1, 4'h4, 0, 1, 8'hB1, 0, rd);
    chk("pushpop_empty", rd, 32'h0);
    do_access(0, 1, 4'h4, 0, 0, 0, 0, rd);
    chk("pushpop_after_empty", rd, 32'h1B1);

    // CTRL config and error interrupt
    do_access(1, 0, 4'hC, 32'h3E, 0, 0, 0, rd);
    rx_event(8'h77, 3'b100);
    repeat (2) @(negedge clock);
    chk("err_irq", 32'(irq), 1);
    chk("cfg_parity", 32'(uart_parity_type), 2);
    chk("cfg_baud", 32'(uart_baud_rate), 3);
    do_access(0, 1, 4'h8, 0, 0, 0, 0, rd);
    chk("err_status", rd & 32'h380, 32'h200);
    do_access(0, 1, 4'h4, 0, 0, 0, 0, rd);
    // W1C of ERR coinciding with a new error: the set must win
    do_access(1, 0, 4'h8, 32'h3E0, 1, 8'h11, 3'b001, rd);
    do_access(0, 1, 4'h8, 0, 0, 0, 0, rd);
    chk("set_wins", rd & 32'h380, 32'h080);

    // Reset in the ACK cycle of a TXDATA write
    @(negedge clock);
    bus_we = 1; bus_addr = 4'h0; bus_wdata = 32'hC3;
    @(posedge clock); #1;
    chk("ack_send_pre_rst", 32'(uart_send), 1);
    bus_we = 0;
    reset_n = 0;
    #1;
    chk("async_send", 32'(uart_send), 0);
    chk("async_ready", 32'(bus_ready), 0);
    chk("async_rdata", bus_rdata, 0);
    chk("async_data", 32'(uart_data), 0);
    chk("async_irq", 32'(irq), 0);
    chk("async_cfg", {28'd0, uart_parity_type, uart_baud_rate}, 0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("no_send_after_rst", 32'(uart_send), 0);
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a;
      int mode;
      logic wr, rdn, wrx;
      logic [2:0] e;
      uart_tx_full = 1'($urandom_range(0, 1));
      uart_tx_empty = 1'($urandom_range(0, 1));
      uart_tx_active = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 9) < 2) begin
        rx_event(8'($urandom), e);
      end else begin
        case ($urandom_range(0, 4))
          0: a = 4'h0; 1: a = 4'h4; 2: a = 4'h8; 3: a = 4'hC;
          default: a = 4'($urandom_range(0, 15));
        endcase
        mode = $urandom_range(0, 3);
        wr  = (mode == 0) || (mode == 2);
        rdn = (mode != 0);
        wrx = ($urandom_range(0, 3) == 0);
        do_access(wr, rdn, a, $urandom, wrx, 8'($urandom), e, rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
